// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 receiver/decoder state types, scancode constants and set-2 to ASCII lookup
package ps2_pkg;

  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {DEC_MAKE, DEC_BREAK, DEC_EXT, DEC_EXT_BREAK} dec_state_t;

  localparam logic [7:0] SC_BREAK   = 8'hF0;
  localparam logic [7:0] SC_EXT     = 8'hE0;
  localparam int         FRAME_BITS = 11;

  // 7'h00 marks an unmapped code; every mapped value is non-zero
  function automatic logic [6:0] scan_to_ascii(input logic [7:0] code);
    case (code)
      8'h1C: return 7'h61;  8'h32: return 7'h62;  8'h21: return 7'h63;  8'h23: return 7'h64;
      8'h24: return 7'h65;  8'h2B: return 7'h66;  8'h34: return 7'h67;  8'h33: return 7'h68;
      8'h43: return 7'h69;  8'h3B: return 7'h6A;  8'h42: return 7'h6B;  8'h4B: return 7'h6C;
      8'h3A: return 7'h6D;  8'h31: return 7'h6E;  8'h44: return 7'h6F;  8'h4D: return 7'h70;
      8'h15: return 7'h71;  8'h2D: return 7'h72;  8'h1B: return 7'h73;  8'h2C: return 7'h74;
      8'h3C: return 7'h75;  8'h2A: return 7'h76;  8'h1D: return 7'h77;  8'h22: return 7'h78;
      8'h35: return 7'h79;  8'h1A: return 7'h7A;
      8'h45: return 7'h30;  8'h16: return 7'h31;  8'h1E: return 7'h32;  8'h26: return 7'h33;
      8'h25: return 7'h34;  8'h2E: return 7'h35;  8'h36: return 7'h36;  8'h3D: return 7'h37;
      8'h3E: return 7'h38;  8'h46: return 7'h39;
      8'h29: return 7'h20;
      default: return 7'h00;
    endcase
  endfunction

endpackage

// File: rtl/ps2_ascii_decoder_if.sv
// rtl/ps2_ascii_decoder_if.sv - keyboard line inputs and decoded key outputs of ps2_ascii_decoder
interface ps2_ascii_decoder_if;
  logic       ps2_clk;
  logic       ps2_dat;
  logic [6:0] ascii;
  logic       key_valid;
  logic       key_held;
  logic       frame_error;

  modport master (output ps2_clk, ps2_dat, input ascii, key_valid, key_held, frame_error);
  modport slave  (input ps2_clk, ps2_dat, output ascii, key_valid, key_held, frame_error);
endinterface

// File: rtl/ps2_rx.sv
// rtl/ps2_rx.sv - PS/2 line synchronizer and 11-bit frame receiver with inactivity timeout
// PS2_PARITY_CHECK_EN: when defined, frames with bad odd parity are discarded as errors.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_dat,
  output logic [7:0] o_byte,
  output logic       o_done,
  output logic       o_err
);
  localparam int             TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]  TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]     LAST_DATA = 3'(FRAME_BITS - 4);

  logic [SYNC_STAGES-1:0] r_clk_sync, r_dat_sync;
  logic                   r_clk_prev;
  rx_state_t              r_state, w_state_next;
  logic [7:0]             r_shift;
  logic [2:0]             r_bit_cnt;
  logic [TW-1:0]          r_timer;
  logic                   r_done, r_err, w_done_next, w_err_next;
  logic                   w_clk_s, w_dat_s, w_fall, w_parity_ok;

  assign w_clk_s = r_clk_sync[SYNC_STAGES-1];
  assign w_dat_s = r_dat_sync[SYNC_STAGES-1];
  assign w_fall  = r_clk_prev & ~w_clk_s;

`ifdef PS2_PARITY_CHECK_EN
  logic r_parity;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                            r_parity <= 1'b0;
    else if (w_fall && r_state == RX_PARITY) r_parity <= w_dat_s;
  end
  assign w_parity_ok = ^{r_shift, r_parity};
`else
  assign w_parity_ok = 1'b1;
`endif

  // Idle-high lines: resetting to 1 avoids a false falling edge after reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clk_sync <= '1;
      r_dat_sync <= '1;
      r_clk_prev <= 1'b1;
    end else begin
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], i_ps2_clk};
      r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], i_ps2_dat};
      r_clk_prev <= w_clk_s;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_done_next  = 1'b0;
    w_err_next   = 1'b0;
    case (r_state)
      RX_IDLE:   if (w_fall && !w_dat_s) w_state_next = RX_DATA;
      RX_DATA:   if (w_fall && r_bit_cnt == LAST_DATA) w_state_next = RX_PARITY;
      RX_PARITY: if (w_fall) w_state_next = RX_STOP;
      RX_STOP: begin
        if (w_fall) begin
          w_state_next = RX_IDLE;
          if (!w_dat_s || !w_parity_ok) w_err_next  = 1'b1;
          else                          w_done_next = 1'b1;
        end
      end
      default: w_state_next = RX_IDLE;
    endcase
    if (r_state != RX_IDLE && !w_fall && r_timer == TO_LAST) begin
      w_state_next = RX_IDLE;
      w_err_next   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= RX_IDLE;
      r_shift   <= 8'h00;
      r_bit_cnt <= 3'd0;
      r_timer   <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= w_done_next;
      r_err   <= w_err_next;
      if (r_state == RX_IDLE || w_fall) r_timer <= '0;
      else                              r_timer <= r_timer + TW'(1);
      if (w_fall && r_state == RX_IDLE) r_bit_cnt <= 3'd0;
      if (w_fall && r_state == RX_DATA) begin
        r_shift   <= {w_dat_s, r_shift[7:1]};
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end
    end
  end

  assign o_byte = r_shift;
  assign o_done = r_done;
  assign o_err  = r_err;
endmodule

// File: rtl/ps2_ascii_decoder.sv
// rtl/ps2_ascii_decoder.sv - PS/2 set-2 keyboard to held-key ASCII decoder (make/break/extended FSM)
module ps2_ascii_decoder
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic              clk,
  input  logic              reset,
  ps2_ascii_decoder_if.slave bus
);
  logic [7:0] w_rx_byte;
  logic       w_rx_done, w_rx_err;
  dec_state_t r_dec, w_dec_next;
  logic [6:0] r_ascii, w_ascii_next, w_map;
  logic       r_key_held, w_held_next, r_key_valid, w_valid_next;

  ps2_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_rx (
    .clk       (clk),
    .reset     (reset),
    .i_ps2_clk (bus.ps2_clk),
    .i_ps2_dat (bus.ps2_dat),
    .o_byte    (w_rx_byte),
    .o_done    (w_rx_done),
    .o_err     (w_rx_err)
  );

  assign w_map = scan_to_ascii(w_rx_byte);

  // Held key is tracked by its ASCII value; mapping is one-to-one so this identifies the code
  always_comb begin
    w_dec_next   = r_dec;
    w_ascii_next = r_ascii;
    w_held_next  = r_key_held;
    w_valid_next = 1'b0;
    if (w_rx_done) begin
      case (r_dec)
        DEC_MAKE: begin
          if (w_rx_byte == SC_BREAK)    w_dec_next = DEC_BREAK;
          else if (w_rx_byte == SC_EXT) w_dec_next = DEC_EXT;
          else if (w_map != 7'h00 && w_map != r_ascii) begin
            w_ascii_next = w_map;
            w_held_next  = 1'b1;
            w_valid_next = 1'b1;
          end
        end
        DEC_BREAK: begin
          w_dec_next = DEC_MAKE;
          if (r_key_held && w_map == r_ascii) begin
            w_ascii_next = 7'h00;
            w_held_next  = 1'b0;
          end
        end
        DEC_EXT:  w_dec_next = (w_rx_byte == SC_BREAK) ? DEC_EXT_BREAK : DEC_MAKE;
        default:  w_dec_next = DEC_MAKE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dec       <= DEC_MAKE;
      r_ascii     <= 7'h00;
      r_key_held  <= 1'b0;
      r_key_valid <= 1'b0;
    end else begin
      r_dec       <= w_dec_next;
      r_ascii     <= w_ascii_next;
      r_key_held  <= w_held_next;
      r_key_valid <= w_valid_next;
    end
  end

  assign bus.ascii       = r_ascii;
  assign bus.key_held    = r_key_held;
  assign bus.key_valid   = r_key_valid;
  assign bus.frame_error = w_rx_err;
endmodule
